// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and sizing helpers for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1010;
   localparam logic [3:0] OP_REMU = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int iter_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

   function automatic logic is_iter_op(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiply and restoring divide, one bit per cycle.
// start_i loads operands; done_o marks the final step, with res_o already holding the answer.
module alu_iter_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] res_o
);

   localparam int CW = iter_cnt_w(WIDTH);

   // MUL: opa = shifted multiplicand, opb = shifted multiplier, acc = partial product.
   // DIV: opa = divisor, opb = dividend shifting into quotient, acc = partial remainder.
   logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [3:0]       op_q, op_d;

   logic [WIDTH-1:0] mul_acc;
   logic [WIDTH:0]   rem_sh;
   logic             fits;
   logic [WIDTH-1:0] div_rem, div_quo;
   logic             last;

   always_comb begin
      mul_acc = acc_q + (opb_q[0] ? opa_q : '0);
      rem_sh  = {acc_q, opb_q[WIDTH-1]};
      fits    = rem_sh >= {1'b0, opa_q};
      div_rem = fits ? WIDTH'(rem_sh - {1'b0, opa_q}) : rem_sh[WIDTH-1:0];
      div_quo = {opb_q[WIDTH-2:0], fits};
   end

   assign last   = busy_q && (cnt_q == CW'(WIDTH - 1));
   assign done_o = last;

   always_comb begin
      res_o = div_rem;
      if (op_q == OP_MUL) begin
         res_o = mul_acc;
      end else if (op_q == OP_DIVU) begin
         res_o = div_quo;
      end
   end

   always_comb begin
      opa_d  = opa_q;
      opb_d  = opb_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      op_d   = op_q;
      if (start_i) begin
         op_d   = op_i;
         acc_d  = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
         if (op_i == OP_MUL) begin
            opa_d = a_i;
            opb_d = b_i;
         end else begin
            opa_d = b_i;
            opb_d = a_i;
         end
      end else if (busy_q) begin
         if (op_q == OP_MUL) begin
            acc_d = mul_acc;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
         end else begin
            acc_d = div_rem;
            opb_d = div_quo;
         end
         if (last) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa_q  <= '0;
         opb_q  <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         op_q   <= '0;
      end else begin
         opa_q  <= opa_d;
         opb_q  <= opb_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         op_q   <= op_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/add/compare ops (latency 1), iterative MUL/DIVU/REMU (latency WIDTH+1).
// Valid/ready on both sides; the result is held while out_ready is low and a new request is taken in the same cycle it drains.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       sel,
   input  logic [WIDTH-1:0] data_1,
   input  logic [WIDTH-1:0] data_2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             z_flag,
   output logic             c_flag,
   output logic             v_flag,
   output logic             n_flag,
   output logic             err
);

   state_t           state_q, state_d;
   logic             live_q;
   logic [WIDTH-1:0] result_q, result_d;
   logic             z_q, z_d, c_q, c_d, v_q, v_d, n_q, n_d, err_q, err_d;
   logic             dz_q, dz_d;

   logic             accept, iter_op, md_done;
   logic [WIDTH-1:0] md_res;
   logic [WIDTH:0]   add_w, sub_w;
   logic [WIDTH-1:0] sc_res;
   logic             sc_c, sc_v, sc_err;

   // live_q keeps in_ready low until the first edge after reset release.
   assign in_ready = live_q && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
   assign accept   = in_valid && in_ready;
   assign iter_op  = is_iter_op(sel);

   alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (accept && iter_op),
      .op_i    (sel),
      .a_i     (data_1),
      .b_i     (data_2),
      .done_o  (md_done),
      .res_o   (md_res)
   );

   always_comb begin
      add_w  = {1'b0, data_1} + {1'b0, data_2};
      sub_w  = {1'b0, data_1} - {1'b0, data_2};
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      sc_err = 1'b0;
      case (sel)
         OP_AND:  sc_res = data_1 & data_2;
         OP_OR:   sc_res = data_1 | data_2;
         OP_NOR:  sc_res = ~(data_1 | data_2);
         OP_ADD: begin
            sc_res = add_w[WIDTH-1:0];
            sc_c   = add_w[WIDTH];
            sc_v   = (data_1[WIDTH-1] == data_2[WIDTH-1]) && (add_w[WIDTH-1] != data_1[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = sub_w[WIDTH-1:0];
            sc_c   = sub_w[WIDTH];
            sc_v   = (data_1[WIDTH-1] != data_2[WIDTH-1]) && (sub_w[WIDTH-1] != data_1[WIDTH-1]);
         end
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(data_1) < $signed(data_2)};
         OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, data_1 < data_2};
         OP_MUL, OP_DIVU, OP_REMU: sc_res = '0;
         default: sc_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      z_d      = z_q;
      c_d      = c_q;
      v_d      = v_q;
      n_d      = n_q;
      err_d    = err_q;
      dz_d     = dz_q;

      case (state_q)
         ST_IDLE: if (accept) state_d = iter_op ? ST_BUSY : ST_DONE;
         ST_BUSY: if (md_done) state_d = ST_DONE;
         ST_DONE: begin
            if (out_ready) begin
               if (accept) state_d = iter_op ? ST_BUSY : ST_DONE;
               else        state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept && !iter_op) begin
         result_d = sc_res;
         z_d      = (sc_res == '0);
         n_d      = sc_res[WIDTH-1];
         c_d      = sc_c;
         v_d      = sc_v;
         err_d    = sc_err;
      end

      // Divide-by-zero is decided at accept; operands are not kept after that edge.
      if (accept && iter_op) begin
         dz_d = (sel != OP_MUL) && (data_2 == '0);
      end

      if ((state_q == ST_BUSY) && md_done) begin
         result_d = md_res;
         z_d      = (md_res == '0);
         n_d      = md_res[WIDTH-1];
         c_d      = 1'b0;
         v_d      = 1'b0;
         err_d    = dz_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         live_q   <= 1'b0;
         result_q <= '0;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         n_q      <= 1'b0;
         err_q    <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         live_q   <= 1'b1;
         result_q <= result_d;
         z_q      <= z_d;
         c_q      <= c_d;
         v_q      <= v_d;
         n_q      <= n_d;
         err_q    <= err_d;
         dz_q     <= dz_d;
      end
   end

   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign z_flag    = z_q;
   assign c_flag    = c_q;
   assign v_flag    = v_q;
   assign n_flag    = n_q;
   assign err       = err_q;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits (legal range 8..64).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operation request valid.
REQ-005 Port: in_ready  output  1  block can accept a request this cycle.
REQ-006 Port: sel  input  4  operation code, sampled on accept.
REQ-007 Port: data_1  input  WIDTH  operand A, sampled on accept.
REQ-008 Port: data_2  input  WIDTH  operand B, sampled on accept.
REQ-009 Port: out_valid  output  1  result and flags valid.
REQ-010 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-011 Port: result  output  WIDTH  registered operation result.
REQ-012 Port: z_flag, c_flag, v_flag, n_flag  output  1 each  zero, carry/borrow, signed overflow, negative (result MSB).
REQ-013 Port: err  output  1  illegal sel or divide-by-zero for the returned result.

Function
REQ-014 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT signed, 0011 SLTU unsigned, 1100 NOR, 1000 MUL (low WIDTH bits), 1010 DIVU, 1011 REMU; SLT/SLTU result 1 or 0 zero-extended.
REQ-015 Accept occurs on a cycle with in_valid and in_ready both high; operands and sel are captured on that edge and are don't-care afterwards.
REQ-016 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-017 IDLE + accept of single-cycle op (AND, OR, ADD, SUB, SLT, SLTU, NOR, illegal) -> DONE next cycle with result registered (latency 1).
REQ-018 IDLE + accept of MUL/DIVU/REMU -> BUSY; iterative shift-add multiply / restoring divide, one bit per cycle; BUSY lasts exactly WIDTH cycles, then DONE (latency WIDTH+1).
REQ-019 in_ready high in IDLE, and in DONE when out_ready is high (back-to-back accept); low in BUSY.
REQ-020 out_valid high exactly in DONE; result, flags, err held stable while out_valid high and out_ready low.
REQ-021 DONE + out_ready without accept -> IDLE; DONE + out_ready with accept -> DONE (single-cycle op) or BUSY (iterative op).
REQ-022 ADD: c_flag = carry-out of bit WIDTH-1; SUB: c_flag = 1 when unsigned data_1 < data_2 (borrow); v_flag = signed overflow for ADD/SUB; c_flag and v_flag 0 for all other ops.
REQ-023 z_flag = (result == 0); n_flag = result[WIDTH-1]; both computed for every op including illegal.
REQ-024 Divide by zero: DIVU result all ones, REMU result = data_1, err = 1, full WIDTH+1 latency retained.
REQ-025 Illegal sel: result 0, z_flag 1, other flags 0, err 1, latency 1.
REQ-026 Arithmetic wraps modulo 2^WIDTH; MUL upper product bits are discarded.
REQ-027 in_valid while in_ready low has no effect; the request must be held by the producer.

Reset
REQ-028 rst_n low asynchronously forces state IDLE, out_valid 0, result 0, all flags 0, err 0, iteration counter 0.
REQ-029 in_ready is 0 while rst_n is low and 1 on the first clock edge after release.
REQ-030 Reset during BUSY or DONE discards the operation; no result is ever presented for it.

Structure
REQ-031 Package alu_pkg holds the opcode constants, FSM state enum, and iteration-count width function ($clog2(WIDTH+1)).
REQ-032 Sub-module alu_iter_muldiv implements the iterative multiply/divide datapath with start/done handshake; seq_alu owns FSM, single-cycle ops, flags and output registers.

Verification
REQ-033 WIDTH=32, ADD 0xFFFFFFFF+1 -> out_valid one cycle after accept, result 0, z=1, c=1, v=0, err=0.
REQ-034 WIDTH=32, SUB 0x80000000-1 -> result 0x7FFFFFFF, v=1, c=0, n=0; SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0.
REQ-035 WIDTH=32, MUL 0x10000 x 0x10001 -> result 0x00010000 after exactly 33 cycles, in_ready low throughout BUSY.
REQ-036 WIDTH=8, DIVU 200/0 -> result 0xFF, err=1; REMU 200/7 -> result 4, err=0, latency 9.
REQ-037 out_ready held low 5 cycles in DONE -> outputs stable, no accept; then out_ready high with in_valid (AND 0xF0,0x3C) -> next-cycle result 0x30, continuous out_valid.
REQ-038 rst_n asserted mid-BUSY of DIVU -> outputs zero immediately; after release, new ADD 2+3 -> result 5, no stale result ever presented.
